// File: rtl/pc_call_stack.sv
// pc_call_stack
//   Program counter plus hardware return-address stack. Consumes the
//   decoder's already-resolved control-flow strobes and produces the next
//   instruction-memory address. One action per enabled cycle, with priority
//   ret > cal > jmp > sequential increment.
//
// Ports
//   clk             : system clock, rising edge
//   rst             : synchronous reset, active high (overrides en/strobes)
//   en              : advance enable, 0 holds all state
//   jmp             : load pc from jmp_addr
//   cal             : push pc+1, then load pc from jmp_addr
//   ret             : pop top of stack into pc
//   jmp_addr        : jump/call target
//   pc              : registered current instruction address
//   stack_level     : number of valid entries, 0..STACK_DEPTH
//   stack_empty     : stack_level == 0
//   stack_full      : stack_level == STACK_DEPTH
//   stack_overflow  : sticky, call attempted while full
//   stack_underflow : sticky, return attempted while empty
module pc_call_stack #(
  parameter int unsigned PC_WIDTH    = 5,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned SP_WIDTH    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                jmp,
  input  logic                cal,
  input  logic                ret,
  input  logic [PC_WIDTH-1:0] jmp_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [SP_WIDTH:0]   stack_level,
  output logic                stack_empty,
  output logic                stack_full,
  output logic                stack_overflow,
  output logic                stack_underflow
);

  localparam logic [SP_WIDTH:0] FULL_LVL = (SP_WIDTH+1)'(STACK_DEPTH);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [SP_WIDTH:0]   lvl_q, lvl_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc;
  logic [SP_WIDTH-1:0] top_idx;
  logic [SP_WIDTH-1:0] push_idx;
  logic                push_en;
  logic                empty, full;

  assign empty    = (lvl_q == '0);
  assign full     = (lvl_q == FULL_LVL);
  // Wraps modulo 2^PC_WIDTH, so a call at the last address pushes 0.
  assign pc_inc   = pc_q + PC_WIDTH'(1);
  // When full the low bits are zero, and the subtraction wraps to the last slot.
  assign top_idx  = lvl_q[SP_WIDTH-1:0] - SP_WIDTH'(1);
  // Only used when not full, so the level always fits in SP_WIDTH bits.
  assign push_idx = lvl_q[SP_WIDTH-1:0];

  always_comb begin
    pc_d    = pc_q;
    lvl_d   = lvl_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (en) begin
      if (ret) begin
        if (!empty) begin
          pc_d  = stack_q[top_idx];
          lvl_d = lvl_q - 1'b1;
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (cal) begin
        pc_d = jmp_addr;
        if (!full) begin
          push_en = 1'b1;
          lvl_d   = lvl_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (jmp) begin
        pc_d = jmp_addr;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (push_en) begin
        stack_q[push_idx] <= pc_inc;
      end
    end
  end

  assign pc              = pc_q;
  assign stack_level     = lvl_q;
  assign stack_empty     = empty;
  assign stack_full      = full;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// tb_pc_call_stack
//   Directed stimulus with hand-computed expectations. The driver applies
//   one vector per cycle on the falling edge and queues what the DUT must
//   show after the next rising edge; an independent monitor pops and
//   compares just after each rising edge.
module tb_pc_call_stack;

  logic       clk;
  logic       rst;
  logic       en;
  logic       jmp;
  logic       cal;
  logic       ret;
  logic [4:0] jmp_addr;
  logic [4:0] pc;
  logic [3:0] stack_level;
  logic       stack_empty;
  logic       stack_full;
  logic       stack_overflow;
  logic       stack_underflow;

  pc_call_stack #(
    .PC_WIDTH   (5),
    .STACK_DEPTH(8),
    .SP_WIDTH   (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .jmp            (jmp),
    .cal            (cal),
    .ret            (ret),
    .jmp_addr       (jmp_addr),
    .pc             (pc),
    .stack_level    (stack_level),
    .stack_empty    (stack_empty),
    .stack_full     (stack_full),
    .stack_overflow (stack_overflow),
    .stack_underflow(stack_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] pc;
    logic [3:0] lvl;
    logic       ovf;
    logic       unf;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Sticky-flag expectations, set by the test sequence when the event occurs.
  logic e_ovf = 1'b0;
  logic e_unf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every rising edge that has a queued expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".pc"},    32'(pc),              32'(e.pc));
        chk({e.tag, ".level"}, 32'(stack_level),     32'(e.lvl));
        chk({e.tag, ".empty"}, 32'(stack_empty),     32'(e.lvl == 4'd0));
        chk({e.tag, ".full"},  32'(stack_full),      32'(e.lvl == 4'd8));
        chk({e.tag, ".ovf"},   32'(stack_overflow),  32'(e.ovf));
        chk({e.tag, ".unf"},   32'(stack_underflow), 32'(e.unf));
      end
    end
  end

  task automatic push_exp(input logic [4:0] epc, input logic [3:0] elvl, input string tag);
    exp_t e;
    e.pc  = epc;
    e.lvl = elvl;
    e.ovf = e_ovf;
    e.unf = e_unf;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic e, input logic j, input logic c, input logic r,
                      input logic [4:0] a, input logic [4:0] epc,
                      input logic [3:0] elvl, input string tag);
    @(negedge clk);
    rst      = 1'b0;
    en       = e;
    jmp      = j;
    cal      = c;
    ret      = r;
    jmp_addr = a;
    push_exp(epc, elvl, tag);
  endtask

  task automatic do_reset(input logic e, input logic j, input logic c, input logic r,
                          input string tag);
    @(negedge clk);
    rst      = 1'b1;
    en       = e;
    jmp      = j;
    cal      = c;
    ret      = r;
    jmp_addr = 5'h1F;
    e_ovf    = 1'b0;
    e_unf    = 1'b0;
    push_exp(5'd0, 4'd0, tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; jmp = 1'b0; cal = 1'b0; ret = 1'b0; jmp_addr = '0;

    // Reset state, then free-running increment with wrap at 31.
    do_reset(1'b1, 1'b0, 1'b0, 1'b0, "reset0");
    for (int i = 1; i <= 33; i++) step(1, 0, 0, 0, 5'd0, 5'(i % 32), 4'd0, "seq");
    // pc is now 1
    step(1, 0, 0, 0, 5'd0, 5'd2, 4'd0, "seq");
    step(1, 0, 0, 0, 5'd0, 5'd3, 4'd0, "seq");
    step(1, 1, 0, 0, 5'h12, 5'h12, 4'd0, "jmp");
    step(1, 0, 0, 0, 5'h00, 5'h13, 4'd0, "jmp_next");

    // Single call/return from pc=3.
    do_reset(1'b1, 1'b0, 1'b1, 1'b1, "reset1");
    step(1, 0, 0, 0, 5'd0, 5'd1, 4'd0, "seq");
    step(1, 0, 0, 0, 5'd0, 5'd2, 4'd0, "seq");
    step(1, 0, 0, 0, 5'd0, 5'd3, 4'd0, "seq");
    step(1, 1, 1, 0, 5'h10, 5'h10, 4'd1, "call1");
    step(1, 0, 0, 0, 5'h00, 5'h11, 4'd1, "call1_idle");
    step(1, 0, 0, 0, 5'h00, 5'h12, 4'd1, "call1_idle");
    step(1, 0, 0, 1, 5'h00, 5'h04, 4'd0, "ret1");

    // Eight nested calls: call k at pc=k-1 pushes k and lands at k.
    do_reset(1'b1, 1'b0, 1'b0, 1'b0, "reset2");
    for (int k = 1; k <= 8; k++) step(1, 1, 1, 0, 5'(k), 5'(k), 4'(k), "nest_call");
    e_ovf = 1'b1;
    step(1, 1, 1, 0, 5'h1F, 5'h1F, 4'd8, "overflow_call");
    for (int k = 8; k >= 1; k--) step(1, 0, 0, 1, 5'd0, 5'(k), 4'(k - 1), "nest_ret");
    // pc is now 1; walk to 7, then return on an empty stack.
    for (int i = 2; i <= 7; i++) step(1, 0, 0, 0, 5'd0, 5'(i), 4'd0, "seq");
    e_unf = 1'b1;
    step(1, 0, 0, 1, 5'd0, 5'd8, 4'd0, "underflow_ret");
    step(1, 0, 0, 0, 5'd0, 5'd9, 4'd0, "sticky_hold");
    do_reset(1'b1, 1'b0, 1'b0, 1'b0, "reset_sticky");

    // Call at pc=31 pushes the wrapped 0; stall holds everything.
    step(1, 1, 0, 0, 5'h1F, 5'h1F, 4'd0, "jmp31");
    step(1, 1, 1, 0, 5'h05, 5'h05, 4'd1, "call_at31");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 5'h0A, 5'h05, 4'd1, "stall");
    step(1, 0, 0, 1, 5'h00, 5'h00, 4'd0, "ret_wrap");

    // All strobes at once: ret wins over cal/jmp.
    step(1, 1, 1, 0, 5'h0A, 5'h0A, 4'd1, "call_a");
    step(1, 1, 1, 1, 5'h15, 5'h01, 4'd0, "prio_ret");
    // jmp with cal low does not push.
    step(1, 1, 0, 0, 5'h07, 5'h07, 4'd0, "jmp_only");

    // Reset in the middle of nested calls discards the stack.
    step(1, 1, 1, 0, 5'h03, 5'h03, 4'd1, "mid_call");
    step(1, 1, 1, 0, 5'h06, 5'h06, 4'd2, "mid_call");
    do_reset(1'b1, 1'b1, 1'b1, 1'b0, "reset_mid");
    e_unf = 1'b1;
    step(1, 0, 0, 1, 5'h00, 5'h01, 4'd0, "ret_after_reset");

    @(negedge clk);
    en = 1'b0; jmp = 1'b0; cal = 1'b0; ret = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
Program-counter and return-address-stack stage that consumes the decoder's control-flow outputs (jmp, cal, ret, jmp_addr) and produces the next instruction address for instruction memory. It holds the PC register and a hardware LIFO of return addresses for CALL/CAL0/CAL1 and RET/RET0/RET1. The decoder has already evaluated the zero_flag conditions, so this block acts on the strobes unconditionally.

Parameters:
PC_WIDTH, 5, width of PC, jmp_addr and each stack entry
STACK_DEPTH, 8, number of return-address entries (power of two, >=2)
SP_WIDTH, 3, log2(STACK_DEPTH); stack_level is SP_WIDTH+1 bits

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  advance enable; 0 = stall, all state held
jmp  input  1  load PC from jmp_addr (also asserted with cal by decoder)
cal  input  1  push return address, then jump
ret  input  1  pop return address into PC
jmp_addr  input  PC_WIDTH  jump/call target
pc  output  PC_WIDTH  registered current instruction address
stack_level  output  SP_WIDTH+1  number of valid entries, 0..STACK_DEPTH
stack_empty  output  1  stack_level == 0
stack_full  output  1  stack_level == STACK_DEPTH
stack_overflow  output  1  sticky: call attempted while full
stack_underflow  output  1  sticky: return attempted while empty

Behaviour:
- Reset (rst=1 at rising edge, overrides en and all strobes): pc=0, stack_level=0, stack_overflow=0, stack_underflow=0, all stack entries cleared to 0. stack_empty=1, stack_full=0.
- stack_empty/stack_full are combinational decodes of stack_level; all other outputs registered.
- en=0: pc, stack_level, stack contents, sticky flags all hold; strobes ignored.
- en=1, one action per cycle, priority ret > cal > jmp > sequential:
  - ret, not empty: pc <= entry[stack_level-1]; stack_level--. Entry contents remain but are invalid.
  - ret, empty: pc <= pc+1; stack_level stays 0; stack_underflow <= 1.
  - cal (jmp ignored), not full: entry[stack_level] <= pc+1; stack_level++; pc <= jmp_addr.
  - cal, full: no push, stack unchanged; pc <= jmp_addr; stack_overflow <= 1.
  - jmp only: pc <= jmp_addr; stack unchanged.
  - none: pc <= pc+1.
- Arithmetic: pc+1 is modulo 2^PC_WIDTH. pc=31 increments to 0; a call at pc=31 pushes 0.
- Latency: new pc is visible one cycle after the strobe edge. A popped address is returned on the cycle after ret, with no extra bubble.
- Sticky flags clear only on reset. They do not block further operation.
- Stack is register-based, indexed by stack_level. No read-during-write hazard: ret and cal are mutually exclusive by priority.
- Reset asserted mid-sequence, e.g. during nested calls, discards all stack state in that cycle.
- Illegal strobe combinations (ret with cal/jmp) resolve by priority. No error is flagged.

Test Plan:
- Reset then 33 cycles with en=1 and no strobes -> pc runs 0,1,…,31,0,1. stack_level stays 0, stack_empty=1.
- At pc=3 assert jmp with jmp_addr=0x12 -> next pc=0x12, then 0x13. stack_level=0.
- At pc=3 assert cal+jmp with jmp_addr=0x10 -> pc=0x10, stack_level=1. Two idle cycles (pc=0x12), then ret -> pc=4, stack_level=0, stack_empty=1.
- Eight nested calls, each to jmp_addr=k -> stack_level=8, stack_full=1. Ninth call to 0x1F -> pc=0x1F, stack_level stays 8, stack_overflow=1. Eight rets -> pc returns in LIFO order, then stack_empty=1. stack_overflow remains 1.
- ret with stack empty at pc=7 -> pc=8, stack_underflow=1, stack_level=0. Assert rst -> both sticky flags 0, pc=0.
- Call at pc=31 to 0x05 -> pushed 0. Hold en=0 for 3 cycles while ret is asserted -> pc stays 5, stack_level stays 1. With en=1, ret -> pc=0.
